pool_sequencer: RTL and testbench

Sequencer for the 2x2 average-pooling stage of the digit-recognition datapath. On `start` it walks a 28x28 signed-pixel image held in a synchronous-read RAM, fetching the four pixels of each non-overlapping 2x2 window. It averages each window and writes the 14x14 (196-entry) pooled map to the pooled-feature RAM in raster order. One window is processed at a time, at a fixed 6 cycles per window, with no stalls.

---
 rtl/pool_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_pool_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_sequencer.sv
// pool_sequencer
// ---------------
// Sequencer for the 2x2 average-pooling stage. After a start request it
// walks an IMG_W x IMG_H signed image held in a synchronous-read RAM. It
// fetches the four pixels of each non-overlapping 2x2 window, averages
// them with a floor (arithmetic shift by 2) and writes the pooled map to
// the pooled-feature RAM in raster order. Each window takes exactly 6
// cycles: 4 FETCH, 1 LAST, 1 WRITE.
//
// Ports
//   clk      : single clock, rising-edge
//   reset    : synchronous active-high reset
//   start    : frame start request, only honoured in IDLE
//   busy     : high while a frame is in progress (FETCH/LAST/WRITE)
//   done     : one-cycle pulse after the final write of a frame
//   rd_en    : image RAM read strobe
//   rd_addr  : image RAM read address
//   rd_data  : image RAM read data, valid the cycle after rd_en
//   wr_en    : pooled RAM write strobe
//   wr_addr  : pooled RAM write address (window index)
//   wr_data  : pooled (averaged) value
//
// All outputs are registered. Their next values are decoded from the
// next-state signals, so each strobe lines up with the state it belongs to.
module pool_sequencer #(
   parameter int RESOLUTION = 8,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int IN_AW      = 10,
   parameter int OUT_AW     = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         rd_en,
   output logic        [IN_AW-1:0]      rd_addr,
   input  logic signed [RESOLUTION-1:0] rd_data,
   output logic                         wr_en,
   output logic        [OUT_AW-1:0]     wr_addr,
   output logic signed [RESOLUTION-1:0] wr_data
);

   localparam int N_WIN = (IMG_W / 2) * (IMG_H / 2);
   localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int ACC_W = RESOLUTION + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LAST,
      S_WRITE,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic        [1:0]          k_q, k_d;
   logic        [COL_W-1:0]    col_q, col_d;
   logic        [ROW_W-1:0]    row_q, row_d;
   logic        [OUT_AW-1:0]   out_idx_q, out_idx_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;

   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic                         rd_en_q, rd_en_d;
   logic        [IN_AW-1:0]      rd_addr_q, rd_addr_d;
   logic                         wr_en_q, wr_en_d;
   logic        [OUT_AW-1:0]     wr_addr_q, wr_addr_d;
   logic signed [RESOLUTION-1:0] wr_data_q, wr_data_d;

   // Sign-extend one pixel to accumulator width.
   function automatic logic signed [ACC_W-1:0] sext(input logic signed [RESOLUTION-1:0] px);
      return ACC_W'(px);
   endfunction

   // Average of four pixels: floor division by 4. The sum of four
   // RESOLUTION-bit values divided by 4 always fits back in RESOLUTION bits.
   function automatic logic signed [RESOLUTION-1:0] avg4(input logic signed [ACC_W-1:0] sum);
      logic signed [ACC_W-1:0] sh;
      sh = sum >>> 2;
      return sh[RESOLUTION-1:0];
   endfunction

   // Pixel address for position kk within the window whose top-left pixel
   // is (r, c): kk[0] selects the right column, kk[1] the lower row.
   function automatic logic [IN_AW-1:0] pix_addr(input logic [1:0]       kk,
                                                 input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
      logic [IN_AW-1:0] base;
      logic [IN_AW-1:0] row_off;
      logic [IN_AW-1:0] col_off;
      base    = IN_AW'(r) * IN_AW'(IMG_W) + IN_AW'(c);
      row_off = kk[1] ? IN_AW'(IMG_W) : '0;
      col_off = kk[0] ? IN_AW'(1) : '0;
      return base + row_off + col_off;
   endfunction

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      col_d     = col_q;
      row_d     = row_q;
      out_idx_d = out_idx_q;
      acc_d     = acc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d       = '0;
               col_d     = '0;
               row_d     = '0;
               out_idx_d = '0;
               state_d   = S_FETCH;
            end
         end

         S_FETCH: begin
            k_d = k_q + 2'd1;
            // rd_data carries the pixel read one cycle earlier, so in the
            // k=0 cycle there is nothing of this window to accumulate yet.
            if (k_q == 2'd1) begin
               acc_d = sext(rd_data);
            end else if (k_q != 2'd0) begin
               acc_d = acc_q + sext(rd_data);
            end
            if (k_q == 2'd3) begin
               state_d = S_LAST;
            end
         end

         S_LAST: begin
            acc_d   = acc_q + sext(rd_data);
            state_d = S_WRITE;
         end

         S_WRITE: begin
            if (out_idx_q == OUT_AW'(N_WIN - 1)) begin
               state_d = S_DONE;
            end else begin
               out_idx_d = out_idx_q + OUT_AW'(1);
               if (col_q == COL_W'(IMG_W - 2)) begin
                  col_d = '0;
                  row_d = row_q + ROW_W'(2);
               end else begin
                  col_d = col_q + COL_W'(2);
               end
               k_d     = '0;
               state_d = S_FETCH;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Output registers are loaded from the state being entered.
      busy_d    = (state_d == S_FETCH) || (state_d == S_LAST) || (state_d == S_WRITE);
      done_d    = (state_d == S_DONE);
      rd_en_d   = (state_d == S_FETCH);
      wr_en_d   = (state_d == S_WRITE);
      rd_addr_d = rd_en_d ? pix_addr(k_d, row_d, col_d) : rd_addr_q;
      wr_addr_d = wr_en_d ? out_idx_d : wr_addr_q;
      wr_data_d = wr_en_d ? avg4(acc_d) : wr_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         col_q     <= '0;
         row_q     <= '0;
         out_idx_q <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         col_q     <= col_d;
         row_q     <= row_d;
         out_idx_q <= out_idx_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_pool_sequencer.sv
// Testbench for pool_sequencer: a 28x28 instance driven by random and
// directed images, checked by a scoreboard fed from a behavioural model,
// plus a 4x4 instance checked against a fixed read/write trace.
module tb_pool_sequencer;

   localparam int W  = 28;
   localparam int H  = 28;
   localparam int NW = (W / 2) * (H / 2);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              start;
   logic              busy, done, rd_en, wr_en;
   logic        [9:0] rd_addr;
   logic        [7:0] wr_addr;
   logic signed [7:0] rd_data = '0;
   logic signed [7:0] wr_data;

   logic              start_s;
   logic              busy_s, done_s, rd_en_s, wr_en_s;
   logic        [3:0] rd_addr_s;
   logic        [1:0] wr_addr_s;
   logic signed [7:0] rd_data_s = '0;
   logic signed [7:0] wr_data_s;

   logic signed [7:0] mem   [0:W*H-1];
   logic signed [7:0] mem_s [0:15];

   pool_sequencer u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   pool_sequencer #(
      .RESOLUTION (8),
      .IMG_W      (4),
      .IMG_H      (4),
      .IN_AW      (4),
      .OUT_AW     (2)
   ) u_small (
      .clk     (clk),
      .reset   (reset),
      .start   (start_s),
      .busy    (busy_s),
      .done    (done_s),
      .rd_en   (rd_en_s),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s),
      .wr_en   (wr_en_s),
      .wr_addr (wr_addr_s),
      .wr_data (wr_data_s)
   );

   // Synchronous-read image RAMs.
   always @(posedge clk) if (rd_en)   rd_data   <= mem[rd_addr];
   always @(posedge clk) if (rd_en_s) rd_data_s <= mem_s[rd_addr_s];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int exp_rd[$];
   int exp_wa[$];
   int exp_wd[$];
   int wr_cnt  = 0;
   int w0_data = 0;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Floor division by 4 using integer remainder arithmetic.
   function automatic int floor4(input int s);
      int r;
      r = s % 4;
      if (r < 0) r += 4;
      return (s - r) / 4;
   endfunction

   // Reference model: the full read-address stream and write stream of one frame.
   task automatic push_frame();
      for (int wy = 0; wy < H / 2; wy++) begin
         for (int wx = 0; wx < W / 2; wx++) begin
            int sum;
            sum = 0;
            for (int dy = 0; dy < 2; dy++) begin
               for (int dx = 0; dx < 2; dx++) begin
                  int a;
                  a = (2 * wy + dy) * W + 2 * wx + dx;
                  exp_rd.push_back(a);
                  sum += int'(mem[a]);
               end
            end
            exp_wa.push_back(wy * (W / 2) + wx);
            exp_wd.push_back(floor4(sum));
         end
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rd_en) begin
         chk("strobe_overlap", int'(wr_en), 0);
         if (exp_rd.size() == 0) chk("rd_unexpected", int'(rd_addr), -1);
         else                    chk("rd_addr", int'(rd_addr), exp_rd.pop_front());
      end
      if (wr_en) begin
         wr_cnt++;
         if (wr_addr == 8'd0) w0_data = int'(wr_data);
         if (exp_wa.size() == 0) begin
            chk("wr_unexpected", int'(wr_addr), -1);
         end else begin
            chk("wr_addr", int'(wr_addr), exp_wa.pop_front());
            chk("wr_data", int'(wr_data), exp_wd.pop_front());
         end
      end
   end

   task automatic kick(output int c0);
      @(negedge clk);
      start = 1'b1;
      c0    = cyc;
   endtask

   // Follows a frame until done (or max_rel cycles after cycle 0); start is
   // released once the relative cycle reaches drop_at.
   task automatic observe(input int c0, input int max_rel, input int drop_at,
                          output int first_rd, output int first_wr, output int last_wr,
                          output int done_rel, output int busy_cnt);
      int rel;
      first_rd = -1; first_wr = -1; last_wr = -1; done_rel = -1; busy_cnt = 0;
      rel = cyc - c0;
      while (done_rel < 0 && rel < max_rel) begin
         @(negedge clk);
         rel = cyc - c0;
         if (rel >= drop_at) start = 1'b0;
         if (rd_en && first_rd < 0) first_rd = rel;
         if (wr_en) begin
            if (first_wr < 0) first_wr = rel;
            last_wr = rel;
         end
         if (busy) busy_cnt++;
         if (done) done_rel = rel;
      end
   endtask

   task automatic full_frame();
      int c0, frd, fwr, lwr, drel, bcnt, w_before;
      w_before = wr_cnt;
      push_frame();
      kick(c0);
      observe(c0, 1400, 1, frd, fwr, lwr, drel, bcnt);
      chk("first_rd", frd, 1);
      chk("first_wr", fwr, 6);
      chk("last_wr", lwr, 6 * NW);
      chk("done_cycle", drel, 6 * NW + 1);
      chk("busy_cycles", bcnt, 6 * NW);
      chk("write_count", wr_cnt - w_before, NW);
      chk("rd_left", exp_rd.size(), 0);
      chk("wr_left", exp_wa.size(), 0);
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
   endtask

   int pat     [5][4] = '{'{127, 127, 127, 127}, '{-128, -128, -128, -128},
                          '{-1, 0, 0, 0}, '{1, 1, 1, 0}, '{3, 3, 3, -2}};
   int pat_exp [5]    = '{127, -128, -1, 0, 1};
   int s_rd_tab[16]   = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
   int s_wd_tab[4]    = '{2, 4, 10, 12};

   initial begin
      int c0, frd, fwr, lwr, drel, bcnt, w_before;
      int rtrace[16];
      int wa_tr[4];
      int wd_tr[4];
      int nrd, nwr, sdone, rel;

      reset   = 1'b1;
      start   = 1'b0;
      start_s = 1'b0;
      for (int i = 0; i < W * H; i++) mem[i] = '0;
      for (int i = 0; i < 16; i++) mem_s[i] = 8'(i);
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_rd_addr", int'(rd_addr), 0);
      chk("rst_wr_addr", int'(wr_addr), 0);
      chk("rst_wr_data", int'(wr_data), 0);
      reset = 1'b0;
      @(negedge clk);

      // Constant image: every pooled value must be 5.
      for (int i = 0; i < W * H; i++) mem[i] = 8'sd5;
      full_frame();
      chk("const_w0", w0_data, 5);

      // Random image.
      for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
      full_frame();

      // Directed window-0 patterns on random background.
      for (int p = 0; p < 5; p++) begin
         for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
         mem[0]     = 8'(pat[p][0]);
         mem[1]     = 8'(pat[p][1]);
         mem[W]     = 8'(pat[p][2]);
         mem[W + 1] = 8'(pat[p][3]);
         full_frame();
         chk("pattern_w0", w0_data, pat_exp[p]);
      end

      // start held high: second frame only begins from IDLE.
      for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
      w_before = wr_cnt;
      push_frame();
      push_frame();
      kick(c0);
      observe(c0, 1400, 1 << 30, frd, fwr, lwr, drel, bcnt);
      chk("hold_done1", drel, 6 * NW + 1);
      observe(c0, 2700, 6 * NW + 3, frd, fwr, lwr, drel, bcnt);
      chk("hold_first_rd2", frd, 6 * NW + 3);
      chk("hold_last_wr2", lwr, 12 * NW + 2);
      chk("hold_done2", drel, 12 * NW + 3);
      chk("hold_busy2", bcnt, 6 * NW);
      repeat (10) @(negedge clk);
      chk("hold_writes", wr_cnt - w_before, 2 * NW);
      chk("hold_rd_left", exp_rd.size(), 0);

      // Reset pulsed during cycle 300 of a frame.
      for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
      push_frame();
      kick(c0);
      observe(c0, 300, 1, frd, fwr, lwr, drel, bcnt);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("postrst_rd_en", int'(rd_en), 0);
      chk("postrst_wr_en", int'(wr_en), 0);
      chk("postrst_busy", int'(busy), 0);
      #1;
      exp_rd.delete();
      exp_wa.delete();
      exp_wd.delete();
      for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
      full_frame();

      // 4x4 instance: fixed trace, start during DONE ignored.
      @(negedge clk);
      start_s = 1'b1;
      c0      = cyc;
      nrd = 0; nwr = 0; sdone = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         rel = cyc - c0;
         if (rel == 1)  start_s = 1'b0;
         if (rel == 25) start_s = 1'b1;
         if (rel == 26) start_s = 1'b0;
         if (rd_en_s) begin
            if (nrd < 16) rtrace[nrd] = int'(rd_addr_s);
            nrd++;
         end
         if (wr_en_s) begin
            if (nwr < 4) begin
               wa_tr[nwr] = int'(wr_addr_s);
               wd_tr[nwr] = int'(wr_data_s);
            end
            nwr++;
         end
         if (done_s && sdone < 0) sdone = rel;
      end
      chk("s_reads", nrd, 16);
      chk("s_writes", nwr, 4);
      chk("s_done_cycle", sdone, 25);
      for (int i = 0; i < 16 && i < nrd; i++) chk("s_rd_addr", rtrace[i], s_rd_tab[i]);
      for (int i = 0; i < 4 && i < nwr; i++) begin
         chk("s_wr_addr", wa_tr[i], i);
         chk("s_wr_data", wd_tr[i], s_wd_tab[i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
